// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

  // Conversion controller states
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Active-low gfedcba segment patterns
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Number of decimal digits needed to show the largest nbits-wide unsigned value
  function automatic int min_digits(input int nbits);
    longint unsigned v;
    int d;
    v = (64'd1 << nbits) - 64'd1;
    d = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/calc_result_display_bcd_to_7seg.sv
// Decodes one BCD digit to active-low 7-segment drive, with forced blank.
// Latency: combinational.
// Backpressure: none.
module bcd_to_7seg
  import calc_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Digit lookup; blank overrides the digit value
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/calc_result_display.sv
// Captures {Carry, C}, converts to BCD by double-dabble, drives registered 7-seg digits.
// Latency: outputs update Word_Length+2 cycles after the accepting edge, with a one-cycle Done pulse.
// Backpressure: none; Result_Valid is only honoured while idle, requests during a run are dropped.
module calc_result_display
  import calc_pkg::*;
#(
  parameter int Word_Length = 6,
  parameter int Num_Digits  = 3,
  parameter int Blank_Zeros = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [Word_Length-1:0]  C,
  input  logic                    Carry,
  input  logic                    Result_Valid,
  output logic                    Busy,
  output logic                    Done,
  output logic [4*Num_Digits-1:0] BCD,
  output logic [7*Num_Digits-1:0] Segments
);

  localparam int N  = Word_Length + 1;
  localparam int BW = 4 * Num_Digits;
  localparam int WW = BW + N;
  localparam int CW = $clog2(N + 1);

  // Display contents after reset: a lone '0' in digit 0
  function automatic logic [7*Num_Digits-1:0] seg_reset();
    logic [7*Num_Digits-1:0] s;
    for (int k = 0; k < Num_Digits; k++) begin
      s[7*k +: 7] = ((k > 0) && (Blank_Zeros != 0)) ? SEG_BLANK : SEG_0;
    end
    return s;
  endfunction

  localparam logic [7*Num_Digits-1:0] SEG_RST = seg_reset();

  // Too few digits for the widest input would silently truncate the display
  if (Num_Digits < min_digits(N)) begin : g_digit_check
    $error("calc_result_display: Num_Digits too small for Word_Length");
  end

  state_t          r_state;
  logic [WW-1:0]   r_work;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [BW-1:0]   r_bcd;
  logic [7*Num_Digits-1:0] r_seg;

  logic [WW-1:0]   w_adj;
  logic [BW-1:0]   w_res;
  logic [Num_Digits-1:0]   w_blank;
  logic [7*Num_Digits-1:0] w_seg;

  assign w_res = r_work[WW-1:N];

  // Add-3 correction on each BCD digit of the work register before the next shift
  always_comb begin
    w_adj = r_work;
    for (int k = 0; k < Num_Digits; k++) begin
      if (r_work[N+4*k +: 4] >= 4'd5) begin
        w_adj[N+4*k +: 4] = r_work[N+4*k +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero blanking: digit k goes dark when it and every digit above it are zero
  always_comb begin
    logic v_zero;
    w_blank = '0;
    v_zero  = 1'b1;
    for (int k = Num_Digits - 1; k >= 1; k--) begin
      v_zero     = v_zero & (w_res[4*k +: 4] == 4'd0);
      w_blank[k] = (Blank_Zeros != 0) & v_zero;
    end
  end

  for (genvar g = 0; g < Num_Digits; g++) begin : g_digit
    bcd_to_7seg u_seg (
      .i_bcd   (w_res[4*g +: 4]),
      .i_blank (w_blank[g]),
      .o_seg   (w_seg[7*g +: 7])
    );
  end

  // Conversion controller: capture, N shift steps, then publish result for one Done cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_seg   <= SEG_RST;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (Result_Valid) begin
            r_work  <= {{BW{1'b0}}, Carry, C};
            r_cnt   <= CW'(N);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_work <= w_adj << 1;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_bcd   <= w_res;
          r_seg   <= w_seg;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Busy     = r_busy;
  assign Done     = r_done;
  assign BCD      = r_bcd;
  assign Segments = r_seg;

endmodule
